// File: rtl/product_accumulator_if.sv
// product_accumulator_if: term input, result output and abort signals between a producer/consumer and the accumulator
interface product_accumulator_if #(parameter int ACC_W = 72);
  logic clear;
  logic in_valid;
  logic [63:0] product;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic [ACC_W-1:0] out_data;
  logic overflow;
  logic [8:0] term_count;
  modport master (
    output clear, in_valid, product, out_ready,
    input in_ready, out_valid, out_data, overflow, term_count
  );
  modport slave (
    input clear, in_valid, product, out_ready,
    output in_ready, out_valid, out_data, overflow, term_count
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums N_TERMS unsigned 64-bit products into an ACC_W result with a sticky carry-out flag
module product_accumulator #(
  parameter int N_TERMS = 8,
  parameter int ACC_W = 72
) (
  input logic clk,
  input logic rst,
  product_accumulator_if.slave bus
);
  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [8:0] LAST = 9'(N_TERMS - 1);
  logic [0:0] state;
  logic [ACC_W-1:0] acc;
  logic ovf;
  logic [8:0] cnt;
  logic [ACC_W:0] sum;
  logic take, give;
  assign sum = {1'b0, acc} + (ACC_W+1)'(bus.product);
  assign take = bus.in_valid && state == ACCUM && !bus.clear;
  assign give = bus.out_ready && state == HOLD && !bus.clear;
  // clear shares the handoff path: both restart an empty batch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (bus.clear || give) begin
      state <= ACCUM;
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (take) begin
      acc <= sum[ACC_W-1:0];
      ovf <= ovf | sum[ACC_W];
      cnt <= cnt + 9'd1;
      state <= cnt == LAST ? HOLD : ACCUM;
    end
  end
  assign bus.in_ready = state == ACCUM;
  assign bus.out_valid = state == HOLD;
  assign bus.out_data = acc;
  assign bus.overflow = ovf;
  assign bus.term_count = cnt;
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The parameter N_TERMS SHALL default to 8 and set the number of products summed per result; legal range is 1..256.
REQ-002 The parameter ACC_W SHALL default to 72 and set the accumulator and result width in bits; legal range is 64..128.
REQ-003 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 clear  input  1  SHALL be a synchronous abort that discards the partial sum or held result.
REQ-006 in_valid  input  1  SHALL indicate that `product` carries a valid 64-bit product from the upstream 32x32 multiplier.
REQ-007 product  input  64  SHALL carry the unsigned product term.
REQ-008 in_ready  output  1  SHALL indicate that the block accepts a term this cycle.
REQ-009 out_valid  output  1  SHALL indicate that a completed sum is presented on out_data.
REQ-010 out_ready  input  1  SHALL indicate that the consumer takes the result.
REQ-011 out_data  output  ACC_W  SHALL carry the unsigned sum of N_TERMS products, truncated to ACC_W bits.
REQ-012 overflow  output  1  SHALL be a sticky flag, asserted when any addition in the current batch carried out of bit ACC_W-1.
REQ-013 term_count  output  9  SHALL report the number of terms accepted in the current batch.

Function
REQ-014 The block SHALL have exactly two states, ACCUM and HOLD.
REQ-015 In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-016 In HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-017 A term transfer SHALL occur on a clock edge where in_valid=1, in_ready=1 and clear=0.
REQ-018 On each transfer, the block SHALL update acc <= (acc + zero-extended product) mod 2^ACC_W, set overflow |= carry-out, and set term_count <= term_count+1.
REQ-019 On the transfer that makes term_count equal N_TERMS, the block SHALL enter HOLD, and out_data SHALL equal the final sum from the next cycle; latency from last accepted term to out_valid is 1 cycle.
REQ-020 In HOLD, out_data, overflow and term_count SHALL stay stable until handoff.
REQ-021 A result handoff SHALL occur on a clock edge where out_valid=1, out_ready=1 and clear=0.
REQ-022 On handoff, the block SHALL return to ACCUM with acc=0, overflow=0 and term_count=0.
REQ-023 No term SHALL be accepted in the handoff cycle, because in_ready=0 in HOLD.
REQ-024 When in_valid=0 in ACCUM, acc, overflow and term_count SHALL hold their values; gaps between terms are unlimited.
REQ-025 clear=1 SHALL take priority over every handshake: the next state SHALL be ACCUM with acc=0, overflow=0 and term_count=0, in either state, and any concurrent term or result SHALL be dropped.
REQ-026 When N_TERMS=1, every accepted term SHALL produce a result one cycle later, so the block sustains one term per two cycles.
REQ-027 The product input SHALL be sampled only on a transfer edge; its value at other times SHALL have no effect.
REQ-028 All outputs SHALL be driven directly from registers or from decode of the state register, with no combinational path from in_valid or out_ready to any output.

Reset
REQ-029 While rst=1, the block SHALL be in ACCUM with acc=0, out_data=0, overflow=0, term_count=0, out_valid=0 and in_ready=1, independent of clk.
REQ-030 Assertion of rst mid-batch or during HOLD SHALL discard all partial and held data.
REQ-031 After rst deasserts, the first transfer SHALL be possible on the first rising edge.

Verification
REQ-032 N_TERMS=4: products 1, 2, 3, 4 back-to-back -> out_valid one cycle after the fourth term, out_data=10, overflow=0, term_count=4.
REQ-033 ACC_W=65, N_TERMS=4: four products of 0xFFFF_FFFF_FFFF_FFFF -> out_data=0x1_FFFF_FFFF_FFFF_FFFC and overflow=1.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and product=7 -> in_ready=0 and out_data is stable throughout; after the handoff the next batch starts with term_count=0 and the first accepted term is 7.
REQ-035 clear asserted after 2 of 4 terms (values 100, 200), then terms 5, 6, 7, 8 -> out_data=26, and the value 300 never appears.
REQ-036 Sparse input: 8 terms of 0x0000_0001_0000_0000 with in_valid toggling every other cycle -> out_data=0x8_0000_0000.
REQ-037 Asynchronous rst pulsed between clock edges during HOLD -> out_valid falls immediately, without waiting for a clock edge, and all outputs take their reset values.
